fetch_queue: RTL and testbench

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the fetch PC and issues sequential requests to the instruction memory over a request/response handshake. Returned instructions are held in an in-order queue, and each one is presented to decode as a valid `{PC, Inst}` pair. Branch redirects and pipeline flushes clear the queue and cancel any responses still in flight.

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues sequential fetches, holds returned words in an
// in-order queue for decode, and cancels in-flight responses on redirect.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        right_valid,
    input  logic        right_ready,
    output logic [31:0] PC,
    output logic [31:0] Inst
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic             done_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cancel_cnt;

    logic             redirect;
    logic [31:0]      redirect_target;
    logic             issue;
    logic             pop;
    logic             fill_found;
    logic [PTR_W-1:0] fill_idx;
    logic [PTR_W-1:0] scan_idx;
    logic [CNT_W-1:0] pending;

    always_comb begin
        redirect        = flush | br_taken;
        redirect_target = flush ? flush_target : br_target;
        inst_req        = ~reset & ~redirect & (count < CNT_W'(DEPTH));
        inst_addr       = fetch_pc;
        right_valid     = done_q[head];
        PC              = pc_q[head];
        Inst            = inst_q[head];
        issue           = inst_req & inst_addr_ok;
        pop             = right_valid & right_ready;
    end

    // Walk live entries from head: first not-done entry receives the next
    // response, and the not-done total is what a redirect must cancel.
    always_comb begin
        fill_found = 1'b0;
        fill_idx   = '0;
        scan_idx   = '0;
        pending    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && !done_q[scan_idx]) begin
                pending = pending + CNT_W'(1);
                if (!fill_found) begin
                    fill_found = 1'b1;
                    fill_idx   = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            pc_q       <= '{default: '0};
            inst_q     <= '{default: '0};
            done_q     <= '{default: 1'b0};
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cancel_cnt <= '0;
        end else if (redirect) begin
            fetch_pc   <= redirect_target;
            done_q     <= '{default: 1'b0};
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            cancel_cnt <= cancel_cnt + pending - CNT_W'(inst_data_ok);
        end else begin
            if (issue) begin
                pc_q[tail]   <= fetch_pc;
                done_q[tail] <= 1'b0;
                tail         <= tail + PTR_W'(1);
                fetch_pc     <= fetch_pc + 32'd4;
            end
            if (inst_data_ok) begin
                if (cancel_cnt != '0) begin
                    cancel_cnt <= cancel_cnt - CNT_W'(1);
                end else if (fill_found) begin
                    inst_q[fill_idx] <= inst_rdata;
                    done_q[fill_idx] <= 1'b1;
                end
            end
            // Popped slots must read not-done so an empty queue shows no valid.
            if (pop) begin
                done_q[head] <= 1'b0;
                head         <= head + PTR_W'(1);
            end
            case ({issue, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency-programmable memory, queue-level reference model
// and directed plus randomized redirect scenarios.
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        flush;
    logic [31:0] flush_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic        right_valid;
    logic        right_ready;
    logic [31:0] PC;
    logic [31:0] Inst;

    fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .flush(flush), .flush_target(flush_target),
        .br_taken(br_taken), .br_target(br_target),
        .right_valid(right_valid), .right_ready(right_ready),
        .PC(PC), .Inst(Inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int unsigned rdy; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; bit done; } ment_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    bit          mem_rand = 1'b0;
    int unsigned mem_lat = 0;
    mreq_t       mem_q[$];
    ment_t       mq[$];
    logic [31:0] mpc;
    int          mcancel;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3c5a96e1 ^ (a << 3);
    endfunction

    function automatic bit m_req();
        return !reset && !(flush || br_taken) && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_rv();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    task automatic drive_mem();
        inst_addr_ok = (mem_q.size() < DEPTH) && (!mem_rand || ($urandom_range(0, 2) != 0));
        inst_data_ok = (mem_q.size() > 0) && (mem_q[0].rdy <= cyc);
        inst_rdata   = inst_data_ok ? memf(mem_q[0].addr) : $urandom;
    endtask

    // One clock: memory and reference model both advance on the values seen before the edge.
    task automatic tick();
        logic s_rst, s_req, s_ok, s_dok, s_rdy, s_fl, s_br, redir, mreq_p, mrv_p, found;
        logic [31:0] s_addr, s_rd, s_ft, s_bt;
        int pend;
        mreq_t e;
        ment_t n;
        s_rst = reset; s_req = inst_req; s_ok = inst_addr_ok; s_dok = inst_data_ok;
        s_rdy = right_ready; s_fl = flush; s_br = br_taken; s_addr = inst_addr;
        s_rd = inst_rdata; s_ft = flush_target; s_bt = br_target;
        mreq_p = m_req(); mrv_p = m_rv();
        @(posedge clk);
        cyc++;
        if (s_rst) begin
            mem_q.delete(); mq.delete(); mpc = RESET_PC; mcancel = 0;
        end else begin
            if (s_dok && mem_q.size() > 0) void'(mem_q.pop_front());
            if (s_req && s_ok) begin
                e.addr = s_addr;
                e.rdy  = cyc + (mem_rand ? $urandom_range(0, 5) : mem_lat);
                mem_q.push_back(e);
            end
            redir = s_fl || s_br;
            if (redir) begin
                pend = 0;
                foreach (mq[k]) if (!mq[k].done) pend++;
                mcancel = mcancel + pend - (s_dok ? 1 : 0);
                mq.delete();
                mpc = s_fl ? s_ft : s_bt;
            end else begin
                if (s_dok) begin
                    if (mcancel > 0) mcancel--;
                    else begin
                        found = 1'b0;
                        foreach (mq[k]) if (!found && !mq[k].done) begin
                            mq[k].inst = s_rd; mq[k].done = 1'b1; found = 1'b1;
                        end
                    end
                end
                if (mrv_p && s_rdy) void'(mq.pop_front());
                if (mreq_p && s_ok) begin
                    n.pc = mpc; n.inst = '0; n.done = 1'b0;
                    mq.push_back(n);
                    mpc = mpc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; br_taken = 1'b0;
        drive_mem(); #1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_deliver(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            flush = 1'b0; br_taken = 1'b0;
            drive_mem(); #1;
            if (right_valid) begin got = 1'b1; return; end
            tick();
        end
    endtask

    task automatic test_reset();
        mem_rand = 1'b0; mem_lat = 0; right_ready = 1'b1;
        flush_target = 32'h0; br_target = 32'h0;
        reset = 1'b1; flush = 1'b0; br_taken = 1'b0;
        drive_mem(); #1;
        n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", inst_req); end
        tick();
        reset = 1'b0;
        drive_mem(); #1;
        n_cmp++; if (right_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rv: got %b want 0", right_valid); end
        n_cmp++; if (PC !== 32'h0 || Inst !== 32'h0) begin n_bad++; $display("FAIL reset_head: got %h/%h want 0/0", PC, Inst); end
        n_cmp++; if (32'(dut.count) !== 32'd0 || 32'(dut.cancel_cnt) !== 32'd0) begin
            n_bad++; $display("FAIL reset_cnt: count %0d cancel %0d want 0 0", dut.count, dut.cancel_cnt); end
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin
            n_bad++; $display("FAIL first_req: got %b %h want 1 %h", inst_req, inst_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        for (int i = 0; i < 12; i++) begin
            right_ready = 1'b1; drive_mem(); #1;
            n_cmp++; if (inst_req !== 1'b1) begin n_bad++; $display("FAIL stream_req c%0d: got %b want 1", i, inst_req); end
            n_cmp++; if (right_valid !== (i >= 2)) begin n_bad++; $display("FAIL stream_rv c%0d: got %b want %b", i, right_valid, i >= 2); end
            if (i >= 2) begin
                ep = RESET_PC + 32'(4 * (i - 2));
                n_cmp++; if (PC !== ep || Inst !== memf(ep)) begin
                    n_bad++; $display("FAIL stream_pc c%0d: got %h/%h want %h/%h", i, PC, Inst, ep, memf(ep)); end
            end
            tick();
        end
    endtask

    task automatic test_full_drain();
        logic [31:0] ep;
        do_reset(); mem_lat = 0;
        for (int i = 0; i < 7; i++) begin
            right_ready = 1'b0; drive_mem(); #1;
            if (i >= 4) begin
                n_cmp++; if (inst_req !== 1'b0 || 32'(dut.count) !== 32'd4) begin
                    n_bad++; $display("FAIL full_hold c%0d: req %b count %0d want 0 4", i, inst_req, dut.count); end
                n_cmp++; if (right_valid !== 1'b1 || PC !== RESET_PC) begin
                    n_bad++; $display("FAIL full_head c%0d: %b %h want 1 %h", i, right_valid, PC, RESET_PC); end
            end
            tick();
        end
        for (int j = 0; j < 6; j++) begin
            right_ready = 1'b1; drive_mem(); #1;
            if (j == 0) begin
                n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL full_pop_req: got %b want 0", inst_req); end
            end
            if (j == 1) begin
                n_cmp++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC + 32'h10) begin
                    n_bad++; $display("FAIL resume_req: got %b %h want 1 %h", inst_req, inst_addr, RESET_PC + 32'h10); end
            end
            ep = RESET_PC + 32'(4 * j);
            n_cmp++; if (right_valid !== 1'b1 || PC !== ep || Inst !== memf(ep)) begin
                n_bad++; $display("FAIL drain %0d: got %b %h/%h want 1 %h/%h", j, right_valid, PC, Inst, ep, memf(ep)); end
            tick();
        end
    endtask

    task automatic test_branch();
        bit got;
        do_reset(); mem_lat = 3; right_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            br_taken = (i == 2); br_target = 32'h1c000100;
            drive_mem(); #1;
            if (i == 2) begin
                n_cmp++; if (inst_req !== 1'b0) begin n_bad++; $display("FAIL br_req_drop: got %b want 0", inst_req); end
            end
            tick();
        end
        br_taken = 1'b0; drive_mem(); #1;
        n_cmp++; if (32'(dut.cancel_cnt) !== 32'd2) begin n_bad++; $display("FAIL br_cancel: got %0d want 2", dut.cancel_cnt); end
        wait_deliver(got);
        n_cmp++; if (!got || PC !== 32'h1c000100 || Inst !== memf(32'h1c000100)) begin
            n_bad++; $display("FAIL br_first: got %b %h/%h want 1 1c000100/%h", got, PC, Inst, memf(32'h1c000100)); end
        tick();
    endtask

    task automatic test_flush_priority();
        bit got;
        do_reset(); mem_lat = 0; right_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 2); br_taken = (i == 2);
            flush_target = 32'h1c008000; br_target = 32'h1c000100;
            drive_mem(); #1;
            tick();
        end
        wait_deliver(got);
        n_cmp++; if (!got || PC !== 32'h1c008000 || Inst !== memf(32'h1c008000)) begin
            n_bad++; $display("FAIL flush_wins: got %b %h/%h want 1 1c008000/%h", got, PC, Inst, memf(32'h1c008000)); end
        tick();
    endtask

    task automatic test_redirect_data_ok();
        bit got;
        do_reset(); mem_lat = 3; right_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 4); flush_target = 32'h1c000200;
            drive_mem(); #1;
            tick();
        end
        flush = 1'b0; drive_mem(); #1;
        n_cmp++; if (32'(dut.cancel_cnt) !== 32'd3) begin n_bad++; $display("FAIL coincident_cancel: got %0d want 3", dut.cancel_cnt); end
        wait_deliver(got);
        n_cmp++; if (!got || PC !== 32'h1c000200 || Inst !== memf(32'h1c000200)) begin
            n_bad++; $display("FAIL coincident_first: got %b %h/%h want 1 1c000200/%h", got, PC, Inst, memf(32'h1c000200)); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr;
        bit prev_pend, rd;
        do_reset(); mem_rand = 1'b1;
        exp_pc = RESET_PC; prev_pend = 1'b0; prev_addr = '0;
        for (int i = 0; i < 1500; i++) begin
            rd = ($urandom_range(0, 11) == 0);
            flush = 1'b0; br_taken = 1'b0;
            if (rd) begin
                case ($urandom_range(0, 2))
                    0: flush = 1'b1;
                    1: br_taken = 1'b1;
                    default: begin flush = 1'b1; br_taken = 1'b1; end
                endcase
            end
            flush_target = $urandom; br_target = $urandom;
            right_ready = ($urandom_range(0, 3) != 0);
            drive_mem(); #1;
            n_cmp++; if (inst_req !== m_req() || (m_req() && inst_addr !== mpc)) begin
                n_bad++; $display("FAIL rnd_req c%0d: got %b %h want %b %h", i, inst_req, inst_addr, m_req(), mpc); end
            n_cmp++; if (right_valid !== m_rv()) begin
                n_bad++; $display("FAIL rnd_rv c%0d: got %b want %b", i, right_valid, m_rv()); end
            if (m_rv()) begin
                n_cmp++; if (PC !== mq[0].pc || Inst !== mq[0].inst) begin
                    n_bad++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", i, PC, Inst, mq[0].pc, mq[0].inst); end
            end
            n_cmp++; if (32'(dut.count) !== 32'(mq.size()) || 32'(dut.cancel_cnt) !== 32'(mcancel)) begin
                n_bad++; $display("FAIL rnd_cnt c%0d: count %0d cancel %0d want %0d %0d", i, dut.count, dut.cancel_cnt, mq.size(), mcancel); end
            if (prev_pend && inst_req) begin
                n_cmp++; if (inst_addr !== prev_addr) begin
                    n_bad++; $display("FAIL addr_stable c%0d: got %h want %h", i, inst_addr, prev_addr); end
            end
            prev_pend = inst_req && !inst_addr_ok; prev_addr = inst_addr;
            if (right_valid && right_ready) begin
                n_cmp++; if (PC !== exp_pc || Inst !== memf(exp_pc)) begin
                    n_bad++; $display("FAIL rnd_deliver c%0d: got %h/%h want %h/%h", i, PC, Inst, exp_pc, memf(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            if (flush) exp_pc = flush_target;
            else if (br_taken) exp_pc = br_target;
            tick();
        end
        flush = 1'b0; br_taken = 1'b0; mem_rand = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset(); mem_lat = 3; right_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            br_taken = (i == 3); br_target = 32'h1c000400;
            drive_mem(); #1;
            tick();
        end
        br_taken = 1'b0; reset = 1'b1; drive_mem(); #1;
        n_cmp++; if (32'(dut.cancel_cnt) !== 32'd3) begin n_bad++; $display("FAIL pre_reset_cancel: got %0d want 3", dut.cancel_cnt); end
        tick();
        reset = 1'b0; drive_mem(); #1;
        n_cmp++; if (32'(dut.cancel_cnt) !== 32'd0 || 32'(dut.count) !== 32'd0 || right_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: cancel %0d count %0d rv %b want 0 0 0", dut.cancel_cnt, dut.count, right_valid); end
        n_cmp++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin
            n_bad++; $display("FAIL mid_reset_pc: got %b %h want 1 %h", inst_req, inst_addr, RESET_PC); end
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; br_taken = 1'b0; right_ready = 1'b0;
        flush_target = '0; br_target = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        mpc = RESET_PC; mcancel = 0;
        test_reset();
        test_stream();
        test_full_drain();
        test_branch();
        test_flush_priority();
        test_redirect_data_ok();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
